// File: rtl/ig_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// ig_pkg - shared types and helpers for the image-gradient datapath
// Rev 1.0
// ----------------------------------------------------------------
package ig_pkg;

  localparam int GRAD_W    = 20;
  localparam int GX_W      = 10;
  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ROW_C = 3'd1,
    S_RD_R  = 3'd2,
    S_RD_D  = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  function automatic logic [GRAD_W-1:0] pack_grad(input logic [GX_W-1:0] gx,
                                                  input logic [GX_W-1:0] gy);
    return {gx, gy};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ig_sched_if.sv
`default_nettype none
// ----------------------------------------------------------------
// ig_sched_if - start/busy/done handshake plus image/gradient memory ports
// Rev 1.0
// ----------------------------------------------------------------
interface ig_sched_if #(
  parameter int ADDR_W = 16
) ();
  import ig_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              img_rd;
  logic [ADDR_W-1:0] img_addr;
  logic [7:0]        img_di;
  logic              grad_wr;
  logic [ADDR_W-1:0] grad_addr;
  logic [GRAD_W-1:0] grad_do;

  modport master (
    input  start, img_di,
    output busy, done, img_rd, img_addr, grad_wr, grad_addr, grad_do
  );

  modport slave (
    output start, img_di,
    input  busy, done, img_rd, img_addr, grad_wr, grad_addr, grad_do
  );

endinterface
`default_nettype wire

// File: rtl/ig_grad_calc.sv
`default_nettype none
// ----------------------------------------------------------------
// ig_grad_calc - combinational forward differences r-c and d-c, packed
// Rev 1.0
// ----------------------------------------------------------------
module ig_grad_calc
  import ig_pkg::*;
(
  input  wire  [7:0]        c_i,
  input  wire  [7:0]        r_i,
  input  wire  [7:0]        d_i,
  output logic [GRAD_W-1:0] grad_o
);

  logic [GX_W-1:0] gx;
  logic [GX_W-1:0] gy;

  // Zero-extend to 10 bits so the difference wraps into two's complement.
  assign gx     = {2'b00, r_i} - {2'b00, c_i};
  assign gy     = {2'b00, d_i} - {2'b00, c_i};
  assign grad_o = pack_grad(gx, gy);

endmodule
`default_nettype wire

// File: rtl/ig_sched.sv
`default_nettype none
// ----------------------------------------------------------------
// ig_sched - raster-scan read sequencer and gradient writer
// Rev 1.0
// ----------------------------------------------------------------
module ig_sched
  import ig_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 16
) (
  input wire         clk,
  input wire         reset,
  ig_sched_if.master bus
);

  localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] Y_LAST   = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

  state_e            state_q;
  logic [ADDR_W-1:0] x_q, y_q;
  logic [ADDR_W-1:0] row0_q, row1_q;
  logic [ADDR_W-1:0] img_addr_q, grad_addr_q;
  logic              busy_q, done_q, img_rd_q;
  logic              cap_c_q, cap_r_q, wr_pend_q;
  logic [7:0]        c_q, r_q;
  logic [GRAD_W-1:0] grad_hold_q;
  logic [GRAD_W-1:0] grad_calc;

  ig_grad_calc u_calc (
    .c_i    (c_q),
    .r_i    (r_q),
    .d_i    (bus.img_di),
    .grad_o (grad_calc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      row0_q      <= '0;
      row1_q      <= '0;
      img_addr_q  <= '0;
      grad_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      img_rd_q    <= 1'b0;
      cap_c_q     <= 1'b0;
      cap_r_q     <= 1'b0;
      wr_pend_q   <= 1'b0;
      c_q         <= '0;
      r_q         <= '0;
      grad_hold_q <= '0;
    end else begin
      // Capture flags mark the one cycle in which img_di carries the
      // pixel requested by the previous read.
      cap_c_q   <= 1'b0;
      cap_r_q   <= 1'b0;
      wr_pend_q <= 1'b0;
      if (cap_c_q) c_q <= bus.img_di;
      if (cap_r_q) r_q <= bus.img_di;
      if (wr_pend_q) begin
        c_q         <= r_q;
        grad_hold_q <= grad_calc;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            x_q        <= '0;
            y_q        <= '0;
            row0_q     <= '0;
            row1_q     <= ROW_STEP;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            img_rd_q   <= 1'b1;
            img_addr_q <= '0;
            state_q    <= S_ROW_C;
          end
        end
        S_ROW_C: begin
          cap_c_q    <= 1'b1;
          img_addr_q <= row0_q + x_q + ONE;
          state_q    <= S_RD_R;
        end
        S_RD_R: begin
          cap_r_q    <= 1'b1;
          img_addr_q <= row1_q + x_q;
          state_q    <= S_RD_D;
        end
        S_RD_D: begin
          wr_pend_q   <= 1'b1;
          grad_addr_q <= row0_q + x_q;
          if (x_q < X_LAST) begin
            x_q        <= x_q + ONE;
            img_addr_q <= row0_q + x_q + TWO;
            state_q    <= S_RD_R;
          end else if (y_q < Y_LAST) begin
            x_q        <= '0;
            y_q        <= y_q + ONE;
            row0_q     <= row1_q;
            row1_q     <= row1_q + ROW_STEP;
            img_addr_q <= row1_q;
            state_q    <= S_ROW_C;
          end else begin
            img_rd_q <= 1'b0;
            state_q  <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.img_rd    = img_rd_q;
  assign bus.img_addr  = img_addr_q;
  assign bus.grad_wr   = wr_pend_q;
  assign bus.grad_addr = grad_addr_q;
  // Outside the write cycle the last written word is held stable.
  assign bus.grad_do   = wr_pend_q ? grad_calc : grad_hold_q;

endmodule
`default_nettype wire
